// File: rtl/score_led_bar.sv
// Registered score-to-LED bar driver: bar/dot pattern, a flash on the newly lit LED
// when the score rises, and a whole-bar blink while the score is at the winning value.
module score_led_bar #(
    parameter int LED_COUNT    = 10,
    parameter int SCORE_WIDTH  = 4,
    parameter int WIN_SCORE    = 10,
    parameter int TICK_DIV     = 5000000,
    parameter int FLASH_CYCLES = 3
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [SCORE_WIDTH-1:0] scoreValue,
    input  logic                   dotMode,
    output logic [LED_COUNT-1:0]   led,
    output logic                   win
);

    localparam int CW          = (SCORE_WIDTH > 6) ? SCORE_WIDTH : 6;
    localparam int TW          = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int FLASH_TICKS = 2 * FLASH_CYCLES;
    localparam int FW          = $clog2(FLASH_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FLASH = 2'd1,
        WIN   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [SCORE_WIDTH-1:0] prevScore_q;
    logic                   first_q;
    logic [TW-1:0]          tickCnt_q, tickCnt_d;
    logic                   phase_q, phase_d;
    logic [FW-1:0]          flashCnt_q, flashCnt_d;
    logic [LED_COUNT-1:0]   led_q, led_d;
    logic                   win_q;

    logic [CW-1:0]          scoreWide, prevWide, nCur, nPrev;
    logic                   tick, atWin, rise, fall, restart;
    logic [LED_COUNT-1:0]   base;

    // Clamp is done at CW bits so a wide score never aliases onto a small LED index.
    always_comb begin
        scoreWide = CW'(scoreValue);
        prevWide  = CW'(prevScore_q);
        nCur      = (scoreWide > CW'(LED_COUNT)) ? CW'(LED_COUNT) : scoreWide;
        nPrev     = (prevWide > CW'(LED_COUNT)) ? CW'(LED_COUNT) : prevWide;
        atWin     = (scoreWide >= CW'(WIN_SCORE));
        rise      = !first_q && (scoreWide > prevWide);
        fall      = !first_q && (scoreWide < prevWide);
        tick      = (tickCnt_q == TW'(TICK_DIV - 1));
        base      = '0;
        for (int i = 0; i < LED_COUNT; i++) begin
            base[i] = dotMode ? (nCur == CW'(i + 1)) : (CW'(i) < nCur);
        end
    end

    always_comb begin
        state_d    = state_q;
        tickCnt_d  = tick ? '0 : tickCnt_q + 1'b1;
        phase_d    = phase_q ^ tick;
        flashCnt_d = flashCnt_q;
        restart    = 1'b0;

        if (atWin) begin
            state_d = WIN;
            restart = (state_q != WIN);
        end else if (state_q == WIN) begin
            state_d = IDLE;
        end else if (rise && (nCur != nPrev)) begin
            state_d = FLASH;
            restart = 1'b1;
        end else if (fall) begin
            state_d = IDLE;
        end else if (state_q == FLASH && tick) begin
            if (flashCnt_q == FW'(FLASH_TICKS - 1)) begin
                state_d = IDLE;
            end else begin
                flashCnt_d = flashCnt_q + 1'b1;
            end
        end

        // A score change always beats a coincident tick: the blink starts over in its off phase.
        if (restart) begin
            tickCnt_d  = '0;
            phase_d    = 1'b0;
            flashCnt_d = '0;
        end

        led_d = base;
        case (state_d)
            FLASH: begin
                for (int i = 0; i < LED_COUNT; i++) begin
                    if (nCur == CW'(i + 1)) begin
                        led_d[i] = phase_d;
                    end
                end
            end
            WIN:     led_d = base & {LED_COUNT{phase_d}};
            default: led_d = base;
        endcase
    end

    // first_q makes the first post-reset score a baseline rather than a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            prevScore_q <= '0;
            first_q     <= 1'b1;
            tickCnt_q   <= '0;
            phase_q     <= 1'b0;
            flashCnt_q  <= '0;
            led_q       <= '0;
            win_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            prevScore_q <= scoreValue;
            first_q     <= 1'b0;
            tickCnt_q   <= tickCnt_d;
            phase_q     <= phase_d;
            flashCnt_q  <= flashCnt_d;
            led_q       <= led_d;
            win_q       <= atWin;
        end
    end

    assign led = led_q;
    assign win = win_q;

endmodule

// File: tb/tb_score_led_bar.sv
// Self-checking bench for score_led_bar: directed literal checks plus randomized
// stimulus compared every cycle against an elapsed-time behavioural model.
module tb_score_led_bar;

    localparam int LC = 10;
    localparam int SW = 4;
    localparam int WS = 10;
    localparam int TD = 4;
    localparam int FC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_FLASH = 1;
    localparam int M_WIN   = 2;

    logic          clock = 1'b0;
    logic          reset;
    logic [SW-1:0] scoreValue;
    logic          dotMode;
    logic [LC-1:0] led;
    logic          win;

    int testsRun    = 0;
    int testsFailed = 0;

    score_led_bar #(
        .LED_COUNT   (LC),
        .SCORE_WIDTH (SW),
        .WIN_SCORE   (WS),
        .TICK_DIV    (TD),
        .FLASH_CYCLES(FC)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .scoreValue(scoreValue),
        .dotMode   (dotMode),
        .led       (led),
        .win       (win)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          prev;
        bit          first;
        int          mode;
        int          el;
        logic [LC-1:0] led;
        logic        win;
    } model_t;

    model_t m;

    // Model tracks cycles elapsed since entering FLASH/WIN; the blink phase is derived from that count.
    function automatic model_t modelNext(model_t cur, logic rst, int s, logic dot);
        model_t        r;
        int            n, np, phase;
        logic [LC-1:0] base;
        r = cur;
        if (rst) begin
            r.prev = 0; r.first = 1; r.mode = M_IDLE; r.el = 0;
            r.led = '0; r.win = 1'b0;
            return r;
        end
        n  = (s > LC) ? LC : s;
        np = (cur.prev > LC) ? LC : cur.prev;
        if (s >= WS) begin
            if (cur.mode != M_WIN) begin r.mode = M_WIN; r.el = 0; end
            else r.el = cur.el + 1;
        end else if (cur.mode == M_WIN) begin
            r.mode = M_IDLE;
        end else if (!cur.first && s > cur.prev && n != np) begin
            r.mode = M_FLASH; r.el = 0;
        end else if (!cur.first && s < cur.prev) begin
            r.mode = M_IDLE;
        end else if (cur.mode == M_FLASH) begin
            r.el = cur.el + 1;
            if (r.el == 2 * FC * TD) r.mode = M_IDLE;
        end
        phase = (r.el / TD) % 2;
        if (dot) base = (n == 0) ? '0 : LC'(1 << (n - 1));
        else     base = LC'((1 << n) - 1);
        r.led = base;
        if (r.mode == M_FLASH) begin
            if (phase == 1) r.led = base | LC'(1 << (n - 1));
            else            r.led = base & ~LC'(1 << (n - 1));
        end else if (r.mode == M_WIN) begin
            r.led = (phase == 1) ? base : '0;
        end
        r.win   = (s >= WS);
        r.prev  = s;
        r.first = 0;
        return r;
    endfunction

    always @(posedge clock) m <= modelNext(m, reset, int'(scoreValue), dotMode);

    always @(negedge clock) begin
        testsRun++;
        if (led !== m.led || win !== m.win) begin
            testsFailed++;
            $display("[TB] FAIL model t=%0t led=%h win=%b expected led=%h win=%b",
                     $time, led, win, m.led, m.win);
        end
    end

    task automatic applyStimulus(input logic rst, input int s, input logic d);
        reset      = rst;
        scoreValue = SW'(s);
        dotMode    = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic checkOutput(input string name, input logic [LC-1:0] expLed, input logic expWin);
        testsRun++;
        if (led !== expLed || win !== expWin) begin
            testsFailed++;
            $display("[TB] FAIL %s led=%h win=%b expected led=%h win=%b",
                     name, led, win, expLed, expWin);
        end
    endtask

    initial begin
        bit [15:0] flashPat;
        int        cur;
        logic      dot;
        logic      rst;
        int        r;
        flashPat   = 16'hF0F0;
        reset      = 1'b1;
        scoreValue = 4'd5;
        dotMode    = 1'b0;

        repeat (3) applyStimulus(1, 5, 0);
        checkOutput("resetHeld", 10'h000, 1'b0);
        applyStimulus(0, 5, 0);
        checkOutput("postResetNoFlash", 10'h01F, 1'b0);
        repeat (5) applyStimulus(0, 5, 0);
        checkOutput("postResetSteady", 10'h01F, 1'b0);

        applyStimulus(0, 2, 0);
        checkOutput("decreaseTo2", 10'h003, 1'b0);
        applyStimulus(0, 2, 0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 3, 0);
            checkOutput("barFlash", flashPat[i] ? 10'h007 : 10'h003, 1'b0);
        end
        repeat (3) applyStimulus(0, 3, 0);
        checkOutput("barFlashDone", 10'h007, 1'b0);

        applyStimulus(0, 3, 1);
        checkOutput("dotScore3", 10'h004, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 4, 1);
            checkOutput("dotFlash", flashPat[i] ? 10'h008 : 10'h000, 1'b0);
        end
        applyStimulus(0, 4, 1);
        checkOutput("dotFlashDone", 10'h008, 1'b0);

        applyStimulus(0, 3, 0);
        checkOutput("fallTo3", 10'h007, 1'b0);
        applyStimulus(0, 2, 0);
        for (int k = 0; k < 6; k++) applyStimulus(0, 3, 0);
        checkOutput("flashCycle5", 10'h007, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 4, 0);
            checkOutput("restartFlash", flashPat[i] ? 10'h00F : 10'h007, 1'b0);
        end
        applyStimulus(0, 4, 0);
        checkOutput("restartDone", 10'h00F, 1'b0);

        applyStimulus(0, 9, 0);
        checkOutput("rise9", 10'h0FF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(0, 10, 0);
            checkOutput("winBlink", flashPat[i] ? 10'h3FF : 10'h000, 1'b1);
        end
        applyStimulus(0, 0, 0);
        checkOutput("winExit", 10'h000, 1'b0);

        applyStimulus(0, 15, 0);
        checkOutput("score15Entry", 10'h000, 1'b1);
        repeat (5) applyStimulus(0, 15, 0);
        checkOutput("score15On", 10'h3FF, 1'b1);
        applyStimulus(1, 15, 0);
        checkOutput("resetMidBlink", 10'h000, 1'b0);

        cur = 15;
        dot = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            r   = $urandom_range(0, 99);
            rst = (r == 99) && ($urandom_range(0, 3) == 0);
            if (r < 6)       cur = $urandom_range(0, 15);
            else if (r < 11) cur = (cur < 15) ? cur + 1 : cur;
            else if (r < 14) cur = (cur > 0) ? cur - 1 : cur;
            if ($urandom_range(0, 39) == 0) dot = ~dot;
            applyStimulus(rst, cur, dot);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/score_led_bar.md
# score_led_bar

Parametrised, registered score-to-LED bar driver for the player score display. Converts a binary score into a bar or single-dot LED pattern of configurable length. When the score rises, the newly lit LED flashes for a set number of blink periods. When the score reaches the winning value, every lit LED blinks until the score falls back. It sits between the score counter and the board LED pins, one instance per player.

## Interface
- LED_COUNT, 10, number of LEDs driven (1..32)
- SCORE_WIDTH, 4, width of the score input
- WIN_SCORE, 10, score at or above which win mode is entered (1..2^SCORE_WIDTH-1)
- TICK_DIV, 5000000, clock cycles per blink half-period (>=1)
- FLASH_CYCLES, 3, full off/on blink periods shown after a score increase (>=1)

- clock  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- scoreValue  input  SCORE_WIDTH  current player score, unsigned
- dotMode  input  1  0 = bar (LEDs 0..n-1 lit), 1 = dot (only LED n-1 lit)
- led  output  LED_COUNT  LED drive, bit 0 = first LED
- win  output  1  high while score >= WIN_SCORE

## Operation
- Display value n = min(scoreValue, LED_COUNT); the clamp is computed at max(SCORE_WIDTH, 6) bits, with no truncation.
- Base pattern, bar mode: bits [n-1:0] set. Dot mode: only bit n-1 set. n = 0 gives all zeros in both modes.
- scoreValue is registered into prevScore every cycle, and changes are detected against prevScore.
- Blink timer: tickCnt counts 0..TICK_DIV-1. It produces a one-cycle tick on wrap, and phase toggles on each tick. Entering FLASH or WIN clears tickCnt and sets phase = 0 (off).
- States:
  - IDLE: led = base pattern. An increase with score < WIN_SCORE goes to FLASH. Score >= WIN_SCORE goes to WIN.
  - FLASH: led = base pattern with bit n-1 forced to phase. After 2*FLASH_CYCLES ticks, go to IDLE.
  - WIN: led = base pattern AND {LED_COUNT{phase}}. Leave WIN to IDLE when score < WIN_SCORE.
- Another increase during FLASH restarts FLASH: the counter clears and the new top LED flashes.
- Any decrease in IDLE or FLASH goes to IDLE immediately, and the base pattern updates.
- An increase whose clamped n equals the previous clamped n (score already >= LED_COUNT) does not enter FLASH.
- Increase to >= WIN_SCORE goes to WIN directly from any state, with no FLASH first.
- dotMode may change at any time. It takes effect on led the next cycle, and the state is unaffected.
- win = (registered score >= WIN_SCORE); it is independent of state.
- Reset mid-operation: the state machine returns to IDLE and all counters clear. The first post-reset score is taken as prevScore, so no flash is triggered.

## Timing
- Reset values: led = 0, win = 0, state = IDLE, prevScore = 0, tickCnt = 0, phase = 0, flash counter = 0.
- The first cycle after reset deasserts treats scoreValue as baseline; no flash occurs.
- All outputs are registered. A scoreValue change at edge k is reflected on led and win after edge k+1.
- FLASH length: exactly 2*FLASH_CYCLES*TICK_DIV cycles.
  - The new top LED is off for the first TICK_DIV cycles, then alternates.
  - It ends steady on.
- WIN blink: off for TICK_DIV cycles, then on for TICK_DIV cycles, repeating from WIN entry.
- Score change and tick in the same cycle: the score change wins, and the timer restarts.

## Test plan
Use LED_COUNT=10, WIN_SCORE=10, TICK_DIV=4, FLASH_CYCLES=2 throughout.
- Reset held with scoreValue=5 -> led=0 and win=0 during reset. After release, led=10'h01F with no flash.
- Bar increase 2->3 -> bit 2 reads 0,0,0,0,1,1,1,1,0,0,0,0,1,1,1,1 over 16 cycles, then stays 1. Bits 1:0 stay 1 throughout.
- Dot mode with score 3 -> led=10'h004. Step to 4: bit 3 flashes 16 cycles, bit 2 drops to 0 immediately.
- Score 9 -> 10 -> win=1 one cycle later. led alternates 10'h000 (4 cycles) / 10'h3FF (4 cycles). Drop to 0 -> led=0, win=0, IDLE.
- Increase 3->4 mid-FLASH (cycle 6) -> bit 3 restarts the 16-cycle flash. Bit 2 shows steady 1.
- Score 15 with SCORE_WIDTH=4 -> led=10'h3FF blinking, win=1. Reset asserted mid-blink -> led=0 next cycle.
